// File: rtl/interp_phase_ctrl.sv
// Phase-accumulator sequencer for the cubic Farrow interpolator: sample loads, float19 mu issue, output-valid alignment.
// Optional STALL-cycle counter enabled by defining INTERP_PHASE_CTRL_UNDERRUN_CNT_EN.
module interp_phase_ctrl #(
    parameter int DATA_WIDTH = 19,
    parameter int PHASE_W    = 16,
    parameter int PIPE_LAT   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [PHASE_W-1:0]    step,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  x_load,
    output logic [DATA_WIDTH-1:0] x_data,
    output logic [DATA_WIDTH-1:0] mu_out,
    output logic                  mu_valid,
    output logic                  out_valid,
    output logic                  busy,
    output logic [15:0]           underrun_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_STALL = 2'd3
    } state_t;

    state_t              state_r;
    logic [PHASE_W-1:0]  phase_r;
    logic [PHASE_W-1:0]  step_r;
    logic [1:0]          fill_cnt_r;
    logic [PIPE_LAT-1:0] vld_pipe_r;

    logic [PHASE_W:0]    nxt_s;
    logic                carry_s;
    logic [PHASE_W-1:0]  frac_s;
    logic                accept_s;
    logic                issue_s;

    // Unsigned fraction f/2^PHASE_W to float19; mantissa is truncated, zero maps to all-zero.
    function automatic logic [DATA_WIDTH-1:0] to_float19(input logic [PHASE_W-1:0] f);
        int                 p_v;
        logic [PHASE_W-1:0] sh_v;
        logic [7:0]         exp_v;
        logic [9:0]         man_v;
        p_v = 0;
        for (int i = 0; i < PHASE_W; i++) begin
            p_v = f[i] ? i : p_v;
        end
        // Shifting the leading one out leaves the lower bits left-aligned.
        sh_v  = f << (PHASE_W - p_v);
        man_v = sh_v[PHASE_W-1 -: 10];
        exp_v = 8'(127 + p_v - PHASE_W);
        return (f == {PHASE_W{1'b0}}) ? {DATA_WIDTH{1'b0}}
                                      : DATA_WIDTH'({1'b0, exp_v, man_v});
    endfunction

    // Next phase and wrap detection.
    always_comb begin
        nxt_s   = {1'b0, phase_r} + {1'b0, step_r};
        carry_s = nxt_s[PHASE_W];
        frac_s  = nxt_s[PHASE_W-1:0];
    end

    // Ready depends only on state, phase and the run request.
    always_comb begin
        case (state_r)
            ST_FILL:  s_ready = enable;
            ST_RUN:   s_ready = enable & carry_s;
            ST_STALL: s_ready = enable;
            default:  s_ready = 1'b0;
        endcase
    end

    // Per-cycle accept and issue decisions.
    always_comb begin
        accept_s = s_ready & s_valid;
        case (state_r)
            ST_RUN:   issue_s = enable & (~carry_s | s_valid);
            ST_STALL: issue_s = enable & s_valid;
            default:  issue_s = 1'b0;
        endcase
    end

    // Sequencer state, phase and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            phase_r    <= {PHASE_W{1'b0}};
            step_r     <= {PHASE_W{1'b0}};
            fill_cnt_r <= 2'd0;
            x_load     <= 1'b0;
            x_data     <= {DATA_WIDTH{1'b0}};
            mu_valid   <= 1'b0;
            mu_out     <= {DATA_WIDTH{1'b0}};
        end else begin
            x_load   <= accept_s;
            mu_valid <= issue_s;
            if (accept_s) begin
                x_data <= s_data;
            end
            if (issue_s) begin
                mu_out <= to_float19(frac_s);
            end
            case (state_r)
                ST_IDLE: begin
                    if (enable && step != {PHASE_W{1'b0}}) begin
                        step_r     <= step;
                        phase_r    <= {PHASE_W{1'b0}};
                        fill_cnt_r <= 2'd0;
                        state_r    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (!enable) begin
                        state_r <= ST_IDLE;
                    end else if (accept_s) begin
                        fill_cnt_r <= fill_cnt_r + 2'd1;
                        if (fill_cnt_r == 2'd3) begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_r <= ST_IDLE;
                    end else if (!carry_s || s_valid) begin
                        phase_r <= frac_s;
                    end else begin
                        state_r <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (!enable) begin
                        state_r <= ST_IDLE;
                    end else if (s_valid) begin
                        phase_r <= frac_s;
                        state_r <= ST_RUN;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Valid delay line; keeps draining regardless of state so in-flight results are delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_r <= {PIPE_LAT{1'b0}};
        end else begin
            vld_pipe_r[0] <= mu_valid;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_pipe_r[i] <= vld_pipe_r[i-1];
            end
        end
    end

    assign out_valid = vld_pipe_r[PIPE_LAT-1];
    assign busy      = (state_r != ST_IDLE);

`ifdef INTERP_PHASE_CTRL_UNDERRUN_CNT_EN
    logic [15:0] underrun_r;

    // Saturating count of cycles spent waiting for a sample at a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_r <= 16'h0000;
        end else if (state_r == ST_STALL && underrun_r != 16'hFFFF) begin
            underrun_r <= underrun_r + 16'h0001;
        end
    end

    assign underrun_cnt = underrun_r;
`else
    assign underrun_cnt = 16'h0000;
`endif

endmodule

// File: doc/interp_phase_ctrl.md
# interp_phase_ctrl

Sequencer for the cubic Farrow interpolator datapath. A fixed-point phase accumulator (NCO) decides when a new input sample enters the 4-tap delay line and which fractional delay mu each output uses. It drives `x_load`/`x_data`/`mu_out` into the interpolator, converts mu to the 19-bit float format (1 sign, 8 exponent with bias 127, 10 mantissa), and tracks pipeline latency so `out_valid` aligns with the interpolator result. It sits between the sample source and the interpolator and supports upsampling only (ratio ≥ 1).

## Interface
- `DATA_WIDTH`, 19: sample and mu float width; only the 19-bit format is supported.
- `PHASE_W`, 16: phase accumulator and step width; legal range 11..24.
- `PIPE_LAT`, 5: cycles from a `mu_valid` issue to the matching interpolator output.
- `clk` in 1: clock; all logic on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: run request.
- `step` in PHASE_W: phase increment per output, equal to 2^PHASE_W / (outputs per input). Captured only on IDLE exit.
- `s_valid` in 1: input sample available.
- `s_data` in DATA_WIDTH: input sample (float19).
- `s_ready` out 1: block accepts `s_data` this cycle. Combinational from state/phase only, never from `s_valid`.
- `x_load` out 1: registered one-cycle strobe that shifts `x_data` into the interpolator delay line.
- `x_data` out DATA_WIDTH: registered sample paired with `x_load`.
- `mu_out` out DATA_WIDTH: registered float19 mu for the current issue.
- `mu_valid` out 1: registered issue strobe; the interpolator computes with `mu_out` this cycle.
- `out_valid` out 1: `mu_valid` delayed by PIPE_LAT cycles.
- `busy` out 1: state ≠ IDLE.
- `underrun_cnt` out 16: stall-cycle counter (see Configuration).

## Operation
- States: IDLE, FILL, RUN, STALL.
- IDLE: `s_ready`=0.
  - If `enable` && `step`≠0: capture `step_r`, set phase←0, fill_cnt←0, go to FILL.
  - If `step`=0: stay in IDLE.
- FILL: `s_ready`=1. Each accepted sample produces `x_load`. No issue. After the 4th accept, go to RUN.
- RUN: compute nxt = phase + `step_r` (PHASE_W+1 bits).
  - No carry: issue `mu_out`=float(nxt[PHASE_W-1:0]), phase←frac.
  - Carry: `s_ready`=1.
    - `s_valid`=1: accept the sample, assert `x_load` and issue together at the same edge, phase←frac.
    - `s_valid`=0: no issue, phase held, go to STALL.
- STALL: `s_ready`=1; `underrun_cnt` increments. On `s_valid`: load and issue float(frac(phase+`step_r`)), update phase, go to RUN.
- `enable`=0 in FILL/RUN/STALL: no accept or issue that cycle; go to IDLE at the next edge. The valid delay line keeps draining, so in-flight `out_valid` pulses are still delivered. Re-enable refills 4 samples.
- mu conversion:
  - f=0 gives 19'h0.
  - Otherwise, with the leading one at bit p: sign=0, exponent=127+p−PHASE_W, mantissa = the bits below p, left-aligned to 10 bits, truncated, zero-filled.
- At most one load per issue, because `step` < 2^PHASE_W.

## Timing
- Reset: all outputs 0, state IDLE, phase 0, valid delay line cleared, `underrun_cnt` 0. Reset mid-operation aborts immediately, with no further strobes.
- Decision in cycle k appears on `x_load`/`mu_valid` in cycle k+1 (1-cycle latency).
- `out_valid` at cycle k+1+PIPE_LAT.
- Throughput: one issue per cycle in RUN with no stall.
- Load on a wrap edge: `x_load` and `mu_valid` are high in the same cycle, and the mu applies to the new delay-line contents.

## Configuration
- `INTERP_PHASE_CTRL_UNDERRUN_CNT_EN`:
  - Defined: `underrun_cnt` counts STALL cycles, saturates at 16'hFFFF, clears only on reset.
  - Undefined: counter logic is removed and `underrun_cnt` is tied to 0.

## Test plan
- Basic step: `step`=16'h4000, samples always valid.
  - 4 FILL loads, then mu sequence 19'h1F400 (0.25), 19'h1F800 (0.5), 19'h1FA00 (0.75), 19'h0 with `x_load`, repeating.
  - One load per 4 issues.
- Step of zero: `step`=0, `enable`=1 → stays IDLE, `busy`=0, no strobes.
- Underrun: `s_valid` drops for 3 cycles at a wrap → no `mu_valid` for 3 cycles, then load+issue together.
  - `underrun_cnt`=3 with the macro, 0 without.
- Valid alignment: a single `mu_valid` at cycle k → exactly one `out_valid` at k+PIPE_LAT.
- Enable drop: `enable`=0 mid-RUN → issues stop next cycle and `busy`=0; pending `out_valid` pulses still appear. Re-enable → 4 FILL loads again.
- Reset mid-STALL: `rst_n` low → all outputs 0 immediately, including in-flight `out_valid`.
